// File: rtl/reg_access_ctrl_pkg.sv
// Shared constants for the register-access controller: instruction field
// positions, opcode encodings, FSM state encoding and opcode class helpers.
package reg_access_ctrl_pkg;

  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int DST_HI  = 11;
  localparam int DST_LO  = 8;
  localparam int SRCA_HI = 7;
  localparam int SRCA_LO = 4;
  localparam int SRCB_HI = 3;
  localparam int SRCB_LO = 0;
  localparam int IMM_HI  = 7;
  localparam int IMM_LO  = 0;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_AND   = 4'h3,
    OP_OR    = 4'h4,
    OP_XOR   = 4'h5,
    OP_LDI   = 4'h6,
    OP_MOV   = 4'h7,
    OP_CMPEQ = 4'h8,
    OP_HALT  = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  // Opcodes that write the register file (ADD..MOV)
  function automatic logic op_writes(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_MOV);
  endfunction

  // Opcodes 9..E have no meaning
  function automatic logic op_illegal(input logic [3:0] op);
    return (op > OP_CMPEQ) && (op != OP_HALT);
  endfunction

  function automatic logic op_sets_carry(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic op_sets_zero(input logic [3:0] op);
    return op_writes(op) || (op == OP_CMPEQ);
  endfunction

endpackage

// File: rtl/reg_alu.sv
// Combinational ALU: computes result, carry/borrow and the next zero flag.
module reg_alu
  import reg_access_ctrl_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [7:0]    imm,
  output logic [DW-1:0] result,
  output logic          carry,
  output logic          zero_next
);

  logic [DW:0] sum;
  logic [DW:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Result and carry per opcode; bit DW of the subtraction is the borrow
  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[DW-1:0];
        carry  = sum[DW];
      end
      OP_SUB: begin
        result = diff[DW-1:0];
        carry  = diff[DW];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_LDI:  result = DW'(imm);
      OP_MOV:  result = a;
      default: result = '0;
    endcase
  end

  // CMPEQ compares operands; every other opcode tests its result
  always_comb begin
    zero_next = (result == '0);
    if (op == OP_CMPEQ) zero_next = (a == b);
  end

endmodule

// File: rtl/reg_access_ctrl.sv
// Serial register-access controller: IDLE -> READ -> EXEC -> WB, one
// instruction every four cycles, with a sticky HALT state.
module reg_access_ctrl
  import reg_access_ctrl_pkg::*;
#(
  parameter int IW = 16,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic [3:0]    src0,
  output logic [3:0]    src1,
  output logic [3:0]    dst,
  output logic [DW-1:0] data,
  output logic          we,
  input  logic [DW-1:0] data0,
  input  logic [DW-1:0] data1,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          zero,
  output logic          carry,
  output logic          err,
  output logic          halted
);

  state_t        state_q, state_d;
  logic [IW-1:0] instr_q;
  logic [DW-1:0] opa_q, opb_q;
  logic [DW-1:0] result_q;
  logic [3:0]    op;
  logic [DW-1:0] alu_result;
  logic          alu_carry;
  logic          alu_zero;

  assign op     = instr_q[OPC_HI:OPC_LO];
  assign result = result_q;
  assign data   = result_q;

  reg_alu #(.DW(DW)) u_alu (
    .op        (op),
    .a         (opa_q),
    .b         (opb_q),
    .imm       (instr_q[IMM_HI:IMM_LO]),
    .result    (alu_result),
    .carry     (alu_carry),
    .zero_next (alu_zero)
  );

  // State, latched instruction, read addresses, operands, result and flags.
  // src0/src1 load on the accept edge so they are already valid in READ;
  // dst loads at end of EXEC so it is valid in WB.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      src0     <= '0;
      src1     <= '0;
      dst      <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            src0    <= instr[SRCA_HI:SRCA_LO];
            src1    <= instr[SRCB_HI:SRCB_LO];
          end
        end
        S_READ: begin
          opa_q <= data0;
          opb_q <= data1;
        end
        S_EXEC: begin
          result_q <= alu_result;
          dst      <= instr_q[DST_HI:DST_LO];
          if (op_sets_carry(op)) carry <= alu_carry;
          if (op_sets_zero(op))  zero  <= alu_zero;
        end
        default: ;
      endcase
    end
  end

  // Next-state and handshake/strobe outputs
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    we          = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    halted      = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = S_READ;
      end
      S_READ: state_d = S_EXEC;
      S_EXEC: state_d = (op == OP_HALT) ? S_HALT : S_WB;
      S_WB: begin
        done    = 1'b1;
        we      = op_writes(op);
        err     = op_illegal(op);
        state_d = S_IDLE;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Self-checking bench for reg_access_ctrl with a behavioural register file
// and an instruction-level reference model.
module tb_reg_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  src0, src1, dst;
  logic [7:0]  data, data0, data1, result;
  logic        we, done, zero, carry, err, halted;

  int n_assert = 0;
  int n_fail   = 0;

  // Register file environment written by the DUT
  logic [7:0] rf [16];
  assign data0 = rf[src0];
  assign data1 = rf[src1];
  always @(posedge clk) if (we) rf[dst] <= data;

  // Reference model state
  logic [7:0] mrf [16];
  logic       mzero = 1'b0;
  logic       mcarry = 1'b0;

  reg_access_ctrl #(.IW(16), .DW(8)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .src0(src0), .src1(src1), .dst(dst),
    .data(data), .we(we), .data0(data0), .data1(data1), .done(done),
    .result(result), .zero(zero), .carry(carry), .err(err), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instruction semantics at the architectural level
  task automatic model(input logic [15:0] ins, output logic [7:0] res,
                       output logic wr, output logic ill);
    int op, a, b, imm, r;
    op  = int'(ins[15:12]);
    a   = int'(mrf[ins[7:4]]);
    b   = int'(mrf[ins[3:0]]);
    imm = int'(ins[7:0]);
    r   = 0;
    wr  = (op >= 1 && op <= 7);
    ill = (op >= 9 && op <= 14);
    case (op)
      1: begin r = (a + b) % 256; mcarry = ((a + b) > 255); end
      2: begin r = (a - b + 256) % 256; mcarry = (a < b); end
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = imm;
      7: r = a;
      8: mzero = (a == b);
      default: ;
    endcase
    res = 8'(r);
    if (wr) begin
      mzero = (r == 0);
      mrf[ins[11:8]] = 8'(r);
    end
  endtask

  // Issue one instruction and check every cycle of its execution
  task automatic do_instr(input logic [15:0] ins, output logic [7:0] o_data,
                          output logic o_we, output logic o_err);
    logic [7:0] res;
    logic wr, ill;
    model(ins, res, wr, ill);
    @(negedge clk);
    check("ready_idle", instr_ready, 1);
    instr = ins; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0; instr = 16'($urandom);
    check("ready_read", instr_ready, 0);
    check("src0_read", src0, ins[7:4]);
    check("src1_read", src1, ins[3:0]);
    check("done_read", done, 0);
    @(negedge clk);
    check("ready_exec", instr_ready, 0);
    check("we_exec", we, 0);
    check("done_exec", done, 0);
    @(negedge clk);
    o_data = data; o_we = we; o_err = err;
    if (ins[15:12] == 4'hF) begin
      check("halted", halted, 1);
      check("ready_halt", instr_ready, 0);
      check("we_halt", we, 0);
      check("done_halt", done, 0);
    end else begin
      check("done_wb", done, 1);
      check("we_wb", we, wr);
      check("err_wb", err, ill);
      check("dst_wb", dst, ins[11:8]);
      check("ready_wb", instr_ready, 0);
      if (wr) check("data_wb", data, res);
      check("zero_wb", zero, mzero);
      check("carry_wb", carry, mcarry);
    end
  endtask

  initial begin
    logic [7:0] od;
    logic       owe, oerr;
    logic [15:0] prog [3];

    // Reset and post-reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_we", we, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_halted", halted, 0);
    check("rst_zero", zero, 0);
    check("rst_carry", carry, 0);
    check("rst_result", result, 0);
    check("rst_data", data, 0);
    check("rst_src0", src0, 0);
    check("rst_src1", src1, 0);
    check("rst_dst", dst, 0);
    check("rst_ready", instr_ready, 1);
    rst = 1'b1;

    // LDI r3,0x2A
    do_instr(16'h632A, od, owe, oerr);
    check("ldi_data", od, 8'h2A);
    check("ldi_we", owe, 1);
    check("ldi_zero", zero, 0);
    @(negedge clk);
    check("ldi_ready_after", instr_ready, 1);

    // Load every register; r1=0xF0, r2=0x20
    for (int i = 0; i < 16; i++) begin
      logic [7:0] v;
      v = (i == 1) ? 8'hF0 : (i == 2) ? 8'h20 : 8'($urandom);
      do_instr({4'h6, 4'(i), v}, od, owe, oerr);
    end

    do_instr(16'h1412, od, owe, oerr);   // ADD r4,r1,r2
    check("add_data", od, 8'h10);
    check("add_carry", carry, 1);
    check("add_zero", zero, 0);
    do_instr(16'h2521, od, owe, oerr);   // SUB r5,r2,r1
    check("sub_data", od, 8'h30);
    check("sub_carry", carry, 1);
    do_instr(16'h8011, od, owe, oerr);   // CMPEQ r1,r1
    check("cmpeq_zero", zero, 1);
    check("cmpeq_we", owe, 0);
    do_instr(16'hA123, od, owe, oerr);   // illegal
    check("ill_err", oerr, 1);
    check("ill_we", owe, 0);
    check("ill_zero", zero, 1);
    check("ill_carry", carry, 1);

    // Back-to-back with instr_valid held high
    prog[0] = 16'h6A11;
    prog[1] = 16'h6B22;
    prog[2] = 16'h1CAB;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k % 4 == 0) begin
        logic [7:0] r;
        logic w, il;
        instr = prog[k / 4];
        instr_valid = 1'b1;
        model(prog[k / 4], r, w, il);
      end
      if (k == 11) instr_valid = 1'b0;
      check("stream_ready", instr_ready, (k % 4 == 0));
      check("stream_done", done, (k % 4 == 3));
      check("stream_we", we, (k % 4 == 3));
      if (k % 4 == 3) begin
        check("stream_dst", dst, prog[k / 4][11:8]);
        check("stream_data", data, mrf[prog[k / 4][11:8]]);
      end
    end

    // Random instructions (no HALT)
    for (int n = 0; n < 40; n++)
      do_instr({4'($urandom_range(0, 14)), 12'($urandom)}, od, owe, oerr);

    // Reset during EXEC of an ADD: no write, everything cleared
    @(negedge clk);
    instr = 16'h1612; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_we", we, 0);
    check("mid_done", done, 0);
    check("mid_result", result, 0);
    check("mid_data", data, 0);
    check("mid_src0", src0, 0);
    check("mid_src1", src1, 0);
    check("mid_dst", dst, 0);
    check("mid_zero", zero, 0);
    check("mid_carry", carry, 0);
    check("mid_ready", instr_ready, 1);
    rst = 1'b1;
    mzero = 1'b0; mcarry = 1'b0;
    @(negedge clk);
    check("mid_ready_after", instr_ready, 1);
    check("mid_no_write", rf[6], mrf[6]);

    // HALT holds with valid high until reset
    do_instr(16'hF000, od, owe, oerr);
    instr_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      instr = 16'($urandom) & 16'h7FFF;
      check("halt_hold", halted, 1);
      check("halt_ready", instr_ready, 0);
      check("halt_we", we, 0);
    end
    instr_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("halt_cleared", halted, 0);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) check("rf_final", rf[i], mrf[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_access_ctrl.md
REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

Interface
REQ-001 SHALL have parameter IW, default 16, instruction width.
REQ-002 SHALL have parameter DW, default 8, register data width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port instr  input  IW  instruction: [15:12] opcode, [11:8] dst, [7:4] srcA, [3:0] srcB; imm = [7:0].
REQ-006 SHALL have port instr_valid  input  1  instr is offered.
REQ-007 SHALL have port instr_ready  output  1  controller accepts instr this cycle.
REQ-008 SHALL have port src0  output  4  register-file read address A.
REQ-009 SHALL have port src1  output  4  register-file read address B.
REQ-010 SHALL have port dst  output  4  register-file write address.
REQ-011 SHALL have port data  output  DW  register-file write data.
REQ-012 SHALL have port we  output  1  register-file write enable.
REQ-013 SHALL have port data0  input  DW  combinational read data for src0.
REQ-014 SHALL have port data1  input  DW  combinational read data for src1.
REQ-015 SHALL have port done  output  1  one-cycle pulse on instruction completion.
REQ-016 SHALL have port result  output  DW  ALU result, valid while done=1.
REQ-017 SHALL have port zero, carry  output  1 each  sticky flags, updated at completion.
REQ-018 SHALL have port err  output  1  one-cycle pulse with done for an illegal opcode.
REQ-019 SHALL have port halted  output  1  high after HALT until reset.

Function
REQ-020 SHALL have FSM states IDLE, READ, EXEC, WB and HALT.
REQ-021 SHALL drive instr_ready=1 only in IDLE; the handshake is instr_valid&&instr_ready; in IDLE it latches instr and moves to READ.
REQ-022 SHALL, in READ, drive src0/src1 from the latched srcA/srcB, capture data0/data1 into operand registers, and move to EXEC.
REQ-023 SHALL, in EXEC, compute and register result/carry, and move to WB (or to HALT for opcode F).
REQ-024 SHALL, in WB, drive dst, data=result, we=1 (for writing opcodes only) and done=1, then return to IDLE; the register write lands on the WB-ending edge.
REQ-025 SHALL use this timing: accept at edge E0, then we/done high during the cycle between E2 and E3; throughput is one instruction per 4 cycles.
REQ-026 SHALL use these opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 LDI (result=imm), 7 MOV (result=A), 8 CMPEQ (zero=(A==B), no write), F HALT.
REQ-027 SHALL set carry for ADD to bit DW of A+B; for SUB, carry=borrow (A<B unsigned); results SHALL wrap modulo 2^DW.
REQ-028 SHALL set zero=(result==0) for every writing opcode; NOP/HALT SHALL leave both flags unchanged; CMPEQ SHALL leave carry unchanged.
REQ-029 SHALL treat opcodes 9-E as illegal: we=0, done=1, err=1, flags unchanged.
REQ-030 SHALL, in HALT, hold instr_ready=0, we=0 and halted=1 regardless of instr_valid.
REQ-031 SHALL hold we=0 and done=0 in every state other than WB; src0/src1/dst SHALL hold their last value outside their active states.
REQ-032 SHALL accept a write with dst equal to a source register; the next instruction reads the new value (no hazard, because execution is serial).

Reset
REQ-033 SHALL, when rst=0 at any rising edge, go to IDLE and zero the following: we, done, err, halted, zero, carry, result, data, src0, src1, dst and the operand registers.
REQ-034 SHALL drop an in-flight instruction when reset is applied mid-operation, with no register write.
REQ-035 SHALL drive instr_ready=1 in the first cycle after rst returns high.

Structure
REQ-036 SHALL take opcode constants, state encodings and field bit positions from a shared package/include used by assembler tests and the top level.
REQ-037 SHALL place the ALU in a sub-module, reg_alu (combinational: op, A, B, imm -> result, carry, zero_next); FSM and registers stay in reg_access_ctrl.

Verification
REQ-038 SHALL check: reset, then LDI r3,0x2A -> WB cycle has dst=3, data=0x2A, we=1, done=1, zero=0; instr_ready returns 1 the next cycle.
REQ-039 SHALL check: with r1=0xF0 and r2=0x20, ADD r4,r1,r2 -> data=0x10, carry=1, zero=0; SUB r5,r2,r1 -> data=0x30, carry=1.
REQ-040 SHALL check: CMPEQ r1,r1 -> zero=1, we=0, done=1; then opcode 0xA -> err=1, we=0, flags unchanged.
REQ-041 SHALL check: instr_valid held high continuously with 3 instructions -> accepts are spaced 4 cycles apart and instr_ready is low in READ/EXEC/WB.
REQ-042 SHALL check: rst=0 during EXEC of ADD -> no we pulse, all outputs zero, IDLE on the next cycle.
REQ-043 SHALL check: HALT -> halted=1 and instr_ready=0 for more than 10 cycles with valid high; reset clears halted.
